// File: rtl/mem_ram_line.sv
// Data-memory model for the data-cache refill path: byte-lane write port plus a
// latency-modelled, word-per-cycle cache-line read whose buffer tracks in-flight writes.
`timescale 1ns/1ps
module mem_ram_line #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LINE_WORDS  = 8,
  parameter int RD_LAT      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_ready,
  output logic                         rd_valid,
  output logic [LINE_WORDS*WORD_W-1:0] rd_data,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [WORD_W-1:0]            wr_data,
  input  logic [1:0]                   mem_wr_sel,
  output logic                         wr_err
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int LINE_W = IDX_W - BEAT_W;
  localparam int LAT_W  = $clog2(RD_LAT + 2);
  localparam int LANES  = WORD_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t              state, state_next;
  logic [LAT_W-1:0]    lat_cnt;
  logic [BEAT_W-1:0]   beat;
  logic [LINE_W-1:0]   line_base;
  logic [WORD_W-1:0]   mem [DEPTH_WORDS];
  logic [WORD_W-1:0]   line_buf [LINE_WORDS];
  logic [WORD_W-1:0]   line_next [LINE_WORDS];

  logic [IDX_W-1:0]    wr_idx;
  logic [LANES-1:0]    wr_be;
  logic [WORD_W-1:0]   wr_lanes;
  logic [WORD_W-1:0]   wr_mask;
  logic                wr_misalign;
  logic                wr_hit_line;
  logic [WORD_W-1:0]   cap_word;
  logic                unused_addr_bits;

  assign wr_idx   = wr_addr[IDX_W+1:2];
  assign rd_ready = (state == S_IDLE);
  assign unused_addr_bits = ^{rd_addr[ADDR_W-1:IDX_W+2], rd_addr[BEAT_W+1:0],
                              wr_addr[ADDR_W-1:IDX_W+2]};

  function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old_word,
                                                   input logic               hit,
                                                   input logic [WORD_W-1:0] data,
                                                   input logic [WORD_W-1:0] mask);
    merge_word = hit ? ((old_word & ~mask) | (data & mask)) : old_word;
  endfunction

  // Replicate the right-justified data across lanes; the enable mask picks the target lanes.
  always_comb begin
    wr_be       = '0;
    wr_lanes    = wr_data;
    wr_misalign = 1'b0;
    case (mem_wr_sel)
      2'b01: begin
        wr_be    = LANES'(1) << wr_addr[1:0];
        wr_lanes = {LANES{wr_data[7:0]}};
      end
      2'b10: begin
        wr_lanes = {(LANES/2){wr_data[15:0]}};
        if (wr_addr[0]) wr_misalign = 1'b1;
        else            wr_be = wr_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b11: begin
        if (wr_addr[1:0] != 2'b00) wr_misalign = 1'b1;
        else                       wr_be = '1;
      end
      default: ;
    endcase
    if (!we) begin
      wr_be       = '0;
      wr_misalign = 1'b0;
    end
    for (int i = 0; i < LANES; i++) wr_mask[8*i +: 8] = {8{wr_be[i]}};
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
  end

  // Buffer words already captured absorb writes; the word captured this edge sees the write too.
  always_comb begin
    wr_hit_line = (wr_be != '0) && (wr_idx[IDX_W-1:BEAT_W] == line_base);
    cap_word    = mem[{line_base, beat}];
    for (int w = 0; w < LINE_WORDS; w++) begin
      line_next[w] = line_buf[w];
      if (state == S_BURST && beat == BEAT_W'(w))
        line_next[w] = merge_word(cap_word, wr_hit_line && wr_idx[BEAT_W-1:0] == beat,
                                  wr_lanes, wr_mask);
      else if (((state == S_BURST && BEAT_W'(w) < beat) || state == S_DONE) &&
               wr_hit_line && wr_idx[BEAT_W-1:0] == BEAT_W'(w))
        line_next[w] = merge_word(line_buf[w], 1'b1, wr_lanes, wr_mask);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (ce && rd_req) begin
                 if (RD_LAT > 0) state_next = S_WAIT;
                 else            state_next = S_BURST;
               end
      S_WAIT:  if (lat_cnt == LAT_W'(RD_LAT - 1)) state_next = S_BURST;
      S_BURST: if (beat == BEAT_W'(LINE_WORDS - 1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // rd_data is only reloaded when leaving DONE, so it holds between rd_valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_cnt   <= '0;
      beat      <= '0;
      line_base <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      wr_err    <= 1'b0;
      for (int w = 0; w < LINE_WORDS; w++) line_buf[w] <= '0;
    end else begin
      state    <= state_next;
      wr_err   <= wr_misalign;
      rd_valid <= (state == S_DONE);
      lat_cnt  <= (state == S_WAIT) ? lat_cnt + 1'b1 : '0;
      beat     <= (state == S_BURST) ? beat + 1'b1 : '0;
      if (state == S_IDLE && ce && rd_req) line_base <= rd_addr[IDX_W+1:BEAT_W+2];
      for (int w = 0; w < LINE_WORDS; w++) line_buf[w] <= line_next[w];
      if (state == S_DONE)
        for (int w = 0; w < LINE_WORDS; w++) rd_data[w*WORD_W +: WORD_W] <= line_next[w];
    end
  end

endmodule

// File: tb/tb_mem_ram_line.sv
// Directed bench for mem_ram_line: table-driven writes and line checks, plus
// hand-written sequences for in-flight coherence, mid-burst reset and a small config.
`timescale 1ns/1ps
module tb_mem_ram_line;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce, rd_req, rd_ready, rd_valid, we, wr_err;
  logic [31:0]  rd_addr, wr_addr, wr_data;
  logic [255:0] rd_data;
  logic [1:0]   mem_wr_sel;

  logic         ce2, rd_req2, rd_ready2, rd_valid2, we2, wr_err2;
  logic [31:0]  rd_addr2, wr_addr2, wr_data2;
  logic [127:0] rd_data2;
  logic [1:0]   mem_wr_sel2;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_ram_line dut (
    .clk(clk), .rst(rst), .ce(ce), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .mem_wr_sel(mem_wr_sel),
    .wr_err(wr_err)
  );

  mem_ram_line #(.RD_LAT(0), .LINE_WORDS(4), .DEPTH_WORDS(16)) dut_small (
    .clk(clk), .rst(rst), .ce(ce2), .rd_req(rd_req2), .rd_addr(rd_addr2),
    .rd_ready(rd_ready2), .rd_valid(rd_valid2), .rd_data(rd_data2),
    .we(we2), .wr_addr(wr_addr2), .wr_data(wr_data2), .mem_wr_sel(mem_wr_sel2),
    .wr_err(wr_err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sel;
    logic        exp_err;
  } wr_vec_t;

  typedef struct {
    int          word;
    logic [31:0] exp;
  } rd_vec_t;

  wr_vec_t wr_vecs[12];
  rd_vec_t rd_vecs[3];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] sel);
    we = 1'b1; wr_addr = addr; wr_data = data; mem_wr_sel = sel;
    tick();
    we = 1'b0; mem_wr_sel = 2'b00;
  endtask

  task automatic read_line(input logic [31:0] addr, output int lat,
                           output logic [255:0] line, output logic ready_low);
    ce = 1'b1; rd_req = 1'b1; rd_addr = addr;
    tick();
    rd_req = 1'b0; lat = -1; line = '0; ready_low = !rd_ready;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (rd_valid) begin
        lat = n; line = rd_data;
        break;
      end
      if (rd_ready) ready_low = 1'b0;
    end
  endtask

  initial begin
    int           lat;
    logic [255:0] line;
    logic         ready_low;
    logic         seen;

    wr_vecs[0]  = '{32'h104, 32'h0000_0000, 2'b11, 1'b0};
    wr_vecs[1]  = '{32'h100, 32'h0000_0011, 2'b01, 1'b0};
    wr_vecs[2]  = '{32'h101, 32'h0000_0022, 2'b01, 1'b0};
    wr_vecs[3]  = '{32'h102, 32'h0000_0033, 2'b01, 1'b0};
    wr_vecs[4]  = '{32'h103, 32'h0000_0044, 2'b01, 1'b0};
    wr_vecs[5]  = '{32'h106, 32'h0000_AABB, 2'b10, 1'b0};
    wr_vecs[6]  = '{32'h108, 32'hFFFF_FFFF, 2'b11, 1'b0};
    wr_vecs[7]  = '{32'h101, 32'h0000_5555, 2'b10, 1'b1};
    wr_vecs[8]  = '{32'h102, 32'h6666_6666, 2'b11, 1'b1};
    wr_vecs[9]  = '{32'h10A, 32'h0000_7777, 2'b10, 1'b0};
    wr_vecs[10] = '{32'h108, 32'h0000_0099, 2'b00, 1'b0};
    wr_vecs[11] = '{32'h109, 32'h1234_5688, 2'b01, 1'b0};
    rd_vecs[0]  = '{0, 32'h4433_2211};
    rd_vecs[1]  = '{1, 32'hAABB_0000};
    rd_vecs[2]  = '{2, 32'h7777_88FF};

    ce = 1'b0; rd_req = 1'b0; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0; mem_wr_sel = '0;
    ce2 = 1'b0; rd_req2 = 1'b0; rd_addr2 = '0; we2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
    mem_wr_sel2 = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    check_output("reset_rd_ready", {31'b0, rd_ready}, 32'd1);
    check_output("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    check_output("reset_rd_data_nonzero", {31'b0, |rd_data}, 32'd0);
    check_output("reset_wr_err", {31'b0, wr_err}, 32'd0);
    check_output("reset_small_rd_ready", {31'b0, rd_ready2}, 32'd1);

    apply_stimulus(32'h40, 32'hDEAD_BEEF, 2'b11);
    read_line(32'h5C, lat, line, ready_low);
    check_output("basic_latency", lat, 32'd11);
    check_output("basic_ready_low", {31'b0, ready_low}, 32'd1);
    check_output("basic_word0", line[31:0], 32'hDEAD_BEEF);
    tick();
    check_output("basic_valid_one_cycle", {31'b0, rd_valid}, 32'd0);
    check_output("basic_data_held", rd_data[31:0], 32'hDEAD_BEEF);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(wr_vecs[i].addr, wr_vecs[i].data, wr_vecs[i].sel);
      check_output($sformatf("wr_err_vec%0d", i), {31'b0, wr_err}, {31'b0, wr_vecs[i].exp_err});
    end
    read_line(32'h100, lat, line, ready_low);
    check_output("lanes_latency", lat, 32'd11);
    for (int i = 0; i < 3; i++)
      check_output($sformatf("lanes_word%0d", rd_vecs[i].word),
                   line[rd_vecs[i].word*32 +: 32], rd_vecs[i].exp);

    // Writes into line 0 while it is being read: WAIT, after capture, and on the capture edge.
    for (int w = 0; w < 9; w++) apply_stimulus(w * 4, 32'h1000_0000 + w, 2'b11);
    ce = 1'b1; rd_req = 1'b1; rd_addr = 32'h0;
    tick();
    rd_req = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      we = 1'b1; mem_wr_sel = 2'b11;
      case (e)
        2:  begin wr_addr = 32'h14; wr_data = 32'h5555_5555; end
        6:  begin wr_addr = 32'h04; wr_data = 32'h1234_5678; end
        8:  begin wr_addr = 32'h20; wr_data = 32'hCAFE_F00D; end
        10: begin wr_addr = 32'h1C; wr_data = 32'h1234_5678; end
        default: begin we = 1'b0; mem_wr_sel = 2'b00; end
      endcase
      tick();
      we = 1'b0; mem_wr_sel = 2'b00;
    end
    check_output("coh_valid", {31'b0, rd_valid}, 32'd1);
    check_output("coh_word0", rd_data[31:0], 32'h1000_0000);
    check_output("coh_word1", rd_data[63:32], 32'h1234_5678);
    check_output("coh_word2", rd_data[95:64], 32'h1000_0002);
    check_output("coh_word5", rd_data[191:160], 32'h5555_5555);
    check_output("coh_word7", rd_data[255:224], 32'h1234_5678);
    read_line(32'h20, lat, line, ready_low);
    check_output("coh_other_line", line[31:0], 32'hCAFE_F00D);

    ce = 1'b1; rd_req = 1'b1; rd_addr = 32'h40;
    tick();
    rd_req = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("abort_rd_valid", {31'b0, rd_valid}, 32'd0);
    check_output("abort_rd_data_nonzero", {31'b0, |rd_data}, 32'd0);
    check_output("abort_rd_ready", {31'b0, rd_ready}, 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (rd_valid) seen = 1'b1;
    end
    check_output("abort_no_valid", {31'b0, seen}, 32'd0);
    read_line(32'h40, lat, line, ready_low);
    check_output("abort_mem_kept", line[31:0], 32'hDEAD_BEEF);

    ce = 1'b0; rd_req = 1'b1; rd_addr = 32'h0;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (!rd_ready || rd_valid) seen = 1'b1;
    end
    rd_req = 1'b0; ce = 1'b1;
    check_output("ce_low_ignored", {31'b0, seen}, 32'd0);

    rd_req = 1'b1; rd_addr = 32'h100;
    tick();
    rd_addr = 32'h40; lat = -1;
    for (int n = 1; n <= 40; n++) begin
      rd_req = (n <= 3);
      tick();
      if (rd_valid) begin
        lat = n;
        break;
      end
    end
    rd_req = 1'b0;
    check_output("busy_latency", lat, 32'd11);
    check_output("busy_first_line", rd_data[31:0], 32'h4433_2211);
    seen = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (rd_valid) seen = 1'b1;
    end
    check_output("busy_no_queue", {31'b0, seen}, 32'd0);

    for (int w = 0; w < 5; w++) begin
      we2 = 1'b1; wr_addr2 = w * 4; wr_data2 = 32'hB0 + w; mem_wr_sel2 = 2'b11;
      tick();
    end
    we2 = 1'b0; mem_wr_sel2 = 2'b00;
    ce2 = 1'b1; rd_req2 = 1'b1; rd_addr2 = 32'h40;
    tick();
    rd_req2 = 1'b0; lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (rd_valid2) begin
        lat = n;
        break;
      end
    end
    check_output("small_latency", lat, 32'd5);
    check_output("small_word0", rd_data2[31:0], 32'h0000_00B0);
    check_output("small_word1", rd_data2[63:32], 32'h0000_00B1);
    check_output("small_word2", rd_data2[95:64], 32'h0000_00B2);
    check_output("small_word3", rd_data2[127:96], 32'h0000_00B3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
